// File: rtl/jtag_shift_ctrl.sv
// JTAG shift controller for one VME-mapped chain. A write strobe launches a TAP reset,
// header, shift and trailer sequence on TCK/TMS/TDI; a read strobe returns the TDO capture.
module jtag_shift_ctrl #(
    parameter int TCK_DIV = 2
) (
    input  logic        FPGACLK,
    input  logic        SYSRST_B,
    input  logic        STRB,
    input  logic        WRITE,
    input  logic [3:0]  FUNC,
    input  logic [3:0]  NBITS_M1,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    output logic        BUSY,
    output logic        DTACK,
    output logic        OVR,
    output logic        TCK,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO
);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_HDR, S_SHIFT, S_TLR, S_DONE} state_t;

    localparam logic [3:0] DIV_LAST = 4'(TCK_DIV - 1);

    state_t      r_state;
    logic        r_ir;
    logic        r_trl;
    logic [3:0]  r_nbits;
    logic [15:0] r_din;
    logic [3:0]  r_bit;
    logic [3:0]  r_div;
    logic        r_tck;
    logic        r_tms;
    logic        r_tdi;
    logic [15:0] r_dout;
    logic        r_busy;
    logic        r_dtack;
    logic        r_ovr;

    state_t      w_start_state;
    state_t      w_next_state;
    state_t      w_adv_state;
    logic        w_last;
    logic [3:0]  w_adv_idx;
    logic [15:0] w_mask;

    // TMS level for TCK period idx of a state; header paths start from Run-Test-Idle.
    function automatic logic tms_for(input state_t st, input logic [3:0] idx,
                                     input logic ir, input logic trl, input logic [3:0] last_bit);
        case (st)
            S_RST:   tms_for = (idx != 4'd5);
            S_HDR:   tms_for = ir ? (idx < 4'd2) : (idx == 4'd0);
            S_SHIFT: tms_for = trl && (idx == last_bit);
            S_TLR:   tms_for = (idx == 4'd0);
            default: tms_for = 1'b0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_last       = 1'b0;
        w_next_state = S_DONE;
        w_mask       = 16'hFFFF >> (4'd15 - NBITS_M1);

        if (FUNC[3])      w_start_state = S_RST;
        else if (FUNC[0]) w_start_state = S_HDR;
        else              w_start_state = S_SHIFT;

        case (r_state)
            S_RST:   w_last = (r_bit == 4'd5);
            S_HDR: begin
                w_last       = (r_bit == (r_ir ? 4'd3 : 4'd2));
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                w_last       = (r_bit == r_nbits);
                w_next_state = r_trl ? S_TLR : S_DONE;
            end
            S_TLR:   w_last = (r_bit == 4'd1);
            default: w_last = 1'b0;
        endcase

        // Counter stops at the last index, so a 16-bit shift never wraps r_bit.
        w_adv_state = w_last ? w_next_state : r_state;
        w_adv_idx   = w_last ? 4'd0 : r_bit + 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset clears
    // every register, including the captured DOUT data.
    always_ff @(posedge FPGACLK or negedge SYSRST_B) begin
        if (!SYSRST_B) begin
            r_state <= S_IDLE;
            r_ir    <= 1'b0;
            r_trl   <= 1'b0;
            r_nbits <= '0;
            r_din   <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_tck   <= 1'b0;
            r_tms   <= 1'b0;
            r_tdi   <= 1'b0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_dtack <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_dtack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (STRB && WRITE) begin
                        r_state <= w_start_state;
                        r_busy  <= 1'b1;
                        r_ir    <= FUNC[2];
                        r_trl   <= FUNC[1];
                        r_nbits <= NBITS_M1;
                        r_din   <= DIN;
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_dout  <= r_dout & w_mask;
                        r_tms   <= tms_for(w_start_state, 4'd0, FUNC[2], FUNC[1], NBITS_M1);
                        if (w_start_state == S_SHIFT) r_tdi <= DIN[0];
                    end else if (STRB) begin
                        r_dtack <= 1'b1;
                        r_ovr   <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_dtack <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    // TCK engine: low half then high half; TDO sampled on the rise,
                    // TMS/TDI updated on the fall that ends each period.
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 4'd1;
                    end else begin
                        r_div <= '0;
                        r_tck <= ~r_tck;
                        if (!r_tck) begin
                            if (r_state == S_SHIFT) r_dout[r_bit] <= TDO;
                        end else begin
                            r_state <= w_adv_state;
                            r_bit   <= w_adv_idx;
                            if (w_adv_state != S_DONE)
                                r_tms <= tms_for(w_adv_state, w_adv_idx, r_ir, r_trl, r_nbits);
                            if (w_adv_state == S_SHIFT) r_tdi <= r_din[w_adv_idx];
                        end
                    end
                end
            endcase
            if (STRB && r_state != S_IDLE) r_ovr <= 1'b1;
        end
    end

    assign DOUT  = r_dout;
    assign BUSY  = r_busy;
    assign DTACK = r_dtack;
    assign OVR   = r_ovr;
    assign TCK   = r_tck;
    assign TMS   = r_tms;
    assign TDI   = r_tdi;

endmodule

// File: tb/tb_jtag_shift_ctrl.sv
// Bench for jtag_shift_ctrl: a TAP state model with a one-bit-delayed TDI->TDO loop,
// a table of directed commands, and hand-written overrun and mid-shift reset sequences.
module tb_jtag_shift_ctrl;

    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUDR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUIR, T_EX2IR, T_UPIR
    } tap_t;

    typedef struct {
        logic        wr;
        logic [3:0]  func;
        logic [3:0]  nb;
        logic [15:0] din;
        int          lat;
        int          n_tck;
        logic [31:0] tms;
        int          n_sh;
        logic [15:0] shd;
        logic [15:0] dout;
        tap_t        tap_end;
    } vec_t;

    logic        fpgaclk = 1'b0;
    logic        sysrst_b;
    logic        strb, write;
    logic [3:0]  func, nbits_m1;
    logic [15:0] din, dout;
    logic        busy, dtack, ovr, tck, tms, tdi, tdo;

    int n_tests = 0;
    int n_fail  = 0;

    tap_t        tap = T_TLR;
    logic        tdo_reg = 1'b0;
    int          tck_cnt;
    logic [31:0] tms_hist;
    int          sh_cnt;
    logic [15:0] sh_data;

    assign tdo = tdo_reg;

    jtag_shift_ctrl #(.TCK_DIV(2)) dut (
        .FPGACLK(fpgaclk), .SYSRST_B(sysrst_b), .STRB(strb), .WRITE(write),
        .FUNC(func), .NBITS_M1(nbits_m1), .DIN(din), .DOUT(dout),
        .BUSY(busy), .DTACK(dtack), .OVR(ovr),
        .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(tdo)
    );

    always #5 fpgaclk = ~fpgaclk;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PAUDR;
            T_PAUDR: return m ? T_EX2DR : T_PAUDR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAUIR;
            T_PAUIR: return m ? T_EX2IR : T_PAUIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            default: return m ? T_SELDR : T_RTI;
        endcase
    endfunction

    // Chain model: shift-state rises capture TDI and present it on TDO one bit later.
    always @(posedge tck) begin
        tck_cnt  = tck_cnt + 1;
        tms_hist = {tms_hist[30:0], tms};
        if (tap == T_SHDR || tap == T_SHIR) begin
            if (sh_cnt < 16) sh_data[sh_cnt] = tdi;
            sh_cnt  = sh_cnt + 1;
            tdo_reg = tdi;
        end
        tap = tap_next(tap, tms);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [3:0] f, input logic [3:0] nb, input logic [15:0] d);
        tck_cnt  = 0;
        tms_hist = '0;
        sh_cnt   = 0;
        sh_data  = '0;
        @(negedge fpgaclk);
        strb = 1'b1; write = wr; func = f; nbits_m1 = nb; din = d;
        @(posedge fpgaclk);
        #1;
        strb = 1'b0; func = ~f; nbits_m1 = ~nb; din = ~d;
    endtask

    // Counts cycles from the accepting edge to the DTACK pulse; inj_at pulses a stray strobe.
    task automatic wait_dtack(input int inj_at, output int lat, output int busy_cyc);
        lat = 1;
        busy_cyc = 0;
        while (!dtack && lat < 3000) begin
            busy_cyc += int'(busy);
            if (lat == inj_at) begin
                strb = 1'b1; write = 1'b1; func = 4'h8;
            end
            @(posedge fpgaclk);
            #1;
            strb = 1'b0;
            lat++;
        end
    endtask

    vec_t vecs[5];

    initial begin
        int lat, bc;

        vecs[0] = '{1'b0, 4'h0, 4'd0,  16'h0000, 1,  0,  32'h0,     0,  16'h0000, 16'h0000, T_TLR};
        vecs[1] = '{1'b1, 4'h8, 4'd0,  16'h0000, 26, 6,  32'h3E,    0,  16'h0000, 16'h0000, T_RTI};
        vecs[2] = '{1'b1, 4'h7, 4'd7,  16'h00E2, 58, 14, 32'h3006,  8,  16'h00E2, 16'h00C4, T_RTI};
        vecs[3] = '{1'b1, 4'h1, 4'd15, 16'hC3A5, 78, 19, 32'h40000, 16, 16'hC3A5, 16'h874B, T_SHDR};
        vecs[4] = '{1'b1, 4'h2, 4'd3,  16'h000A, 26, 6,  32'h6,     4,  16'h000A, 16'h0005, T_RTI};

        sysrst_b = 1'b0; strb = 1'b0; write = 1'b0; func = '0; nbits_m1 = '0; din = '0;
        tck_cnt = 0; tms_hist = '0; sh_cnt = 0; sh_data = '0;
        #1;
        check("reset_outputs", {dout, busy, dtack, ovr, tck, tms, tdi}, 32'h0);
        repeat (3) @(posedge fpgaclk);
        @(negedge fpgaclk);
        sysrst_b = 1'b1;

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].wr, vecs[i].func, vecs[i].nb, vecs[i].din);
            wait_dtack(-1, lat, bc);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].wr ? vecs[i].lat - 1 : 0);
            check($sformatf("v%0d_busy_at_dtack", i), busy, 0);
            check($sformatf("v%0d_tck_periods", i), tck_cnt, vecs[i].n_tck);
            check($sformatf("v%0d_tms_seq", i), tms_hist, vecs[i].tms);
            check($sformatf("v%0d_shift_bits", i), sh_cnt, vecs[i].n_sh);
            check($sformatf("v%0d_tdi_data", i), sh_data, vecs[i].shd);
            check($sformatf("v%0d_dout", i), dout, vecs[i].dout);
            check($sformatf("v%0d_tap_end", i), tap, vecs[i].tap_end);
            check($sformatf("v%0d_ovr", i), ovr, 0);
            check($sformatf("v%0d_tck_idle", i), tck, 0);
            @(posedge fpgaclk); #1;
            check($sformatf("v%0d_dtack_one_cycle", i), dtack, 0);
        end

        // Overrun: a write strobe mid-shift must not disturb the running command.
        send(1'b1, 4'h3, 4'd7, 16'h005A);
        wait_dtack(20, lat, bc);
        check("ovr_latency", lat, 54);
        check("ovr_flag_set", ovr, 1);
        check("ovr_tms_seq", tms_hist, 32'h1006);
        check("ovr_tdi_data", sh_data, 16'h005A);
        check("ovr_dout", dout, 16'h00B5);
        check("ovr_tap_end", tap, T_RTI);
        send(1'b0, 4'h0, 4'd0, 16'h0000);
        wait_dtack(-1, lat, bc);
        check("read_latency", lat, 1);
        check("read_clears_ovr", ovr, 0);
        check("read_dout_stable", dout, 16'h00B5);

        // Reset while bit 5 of a 16-bit DR shift is in flight.
        send(1'b1, 4'h1, 4'd15, 16'hFFFF);
        for (int c = 0; c < 500 && sh_cnt < 5; c++) @(posedge fpgaclk);
        check("midrst_reached_bit5", sh_cnt, 5);
        #2;
        sysrst_b = 1'b0;
        #1;
        check("midrst_outputs", {dout, busy, dtack, ovr, tck, tms, tdi}, 32'h0);
        bc = 0;
        repeat (3) begin
            @(posedge fpgaclk); #1;
            bc += int'(dtack);
        end
        check("midrst_no_dtack", bc, 0);
        @(negedge fpgaclk);
        sysrst_b = 1'b1;

        send(1'b1, 4'h8, 4'd0, 16'h0000);
        wait_dtack(-1, lat, bc);
        check("post_rst_latency", lat, 26);
        check("post_rst_tms_seq", tms_hist, 32'h3E);
        check("post_rst_tap_end", tap, T_RTI);
        check("post_rst_dout", dout, 16'h0000);
        check("post_rst_ovr", ovr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
